op_sequencer: RTL and testbench

- Hardware replacement for the bench-side driver that feeds `core`.
- Queues host op codes, waits for the core's o_op_ready pulse, then issues one op_valid/op_mode beat.
- For load ops (mode 0), streams IFMAP_BYTES bytes from a 1-cycle-latency byte memory into the core's in_valid/in_ready port.
- Sits directly upstream of `core`; its outputs wire straight to i_op_valid, i_op_mode, i_in_valid and i_in_data.

---
 rtl/seq_pkg.sv | 14 +
 rtl/op_cmd_fifo.sv | 51 +++++
 rtl/op_sequencer.sv | 150 +++++++++++++++
 tb/tb_op_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the op sequencer that feeds the core.
package seq_pkg;

    localparam logic [3:0] OP_LOAD         = 4'd0;
    localparam int         IFMAP_BYTES_DEF = 2048;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        LOAD,
        DONE
    } state_t;

endpackage

// File: rtl/op_cmd_fifo.sv
// Synchronous op-code queue. A push on a full queue succeeds only alongside a pop.
module op_cmd_fifo #(
    parameter int CMD_DEPTH = 16,
    parameter int WIDTH     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(CMD_DEPTH);

    logic [WIDTH-1:0] mem [CMD_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == (PTR_W+1)'(CMD_DEPTH));
    assign empty   = (count == '0);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/op_sequencer.sv
// Issues queued op codes to the core on its ready pulse and streams the
// ifmap from byte memory through a 2-entry skid buffer for load ops.
module op_sequencer
    import seq_pkg::*;
#(
    parameter int CMD_DEPTH   = 16,
    parameter int IFMAP_BYTES = IFMAP_BYTES_DEF,
    parameter int ADDR_W      = 11
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_valid,
    input  logic [3:0]        i_cmd_mode,
    output logic              o_cmd_ready,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [7:0]        i_mem_data,
    input  logic              i_op_ready,
    output logic              o_op_valid,
    output logic [3:0]        o_op_mode,
    input  logic              i_in_ready,
    output logic              o_in_valid,
    output logic [7:0]        o_in_data,
    output logic              o_busy,
    output logic              o_load_done
);

    localparam int              CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0] N_BYTES   = CNT_W'(IFMAP_BYTES);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(IFMAP_BYTES - 1);

    state_t           state, state_d;
    logic             ready_pend, pend_d;
    logic [3:0]       mode_q;
    logic             fifo_pop, fifo_full, fifo_empty;
    logic [3:0]       fifo_head;

    logic [1:0]       occ_p0;
    logic             rd_vld_p1;
    logic [7:0]       skid0_p1, skid1_p1;
    logic [CNT_W-1:0] addr_q;
    logic [CNT_W-1:0] byte_cnt;
    logic [2:0]       fill;
    logic             accept;

    op_cmd_fifo #(
        .CMD_DEPTH (CMD_DEPTH),
        .WIDTH     (4)
    ) u_cmd_fifo (
        .clk     (i_clk),
        .rst     (i_rst),
        .wr_en   (i_cmd_valid),
        .wr_data (i_cmd_mode),
        .rd_en   (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Beats toward the core are suppressed in any cycle the core pulses ready.
    assign o_in_valid  = (state == LOAD) && (occ_p0 != 2'd0) && !i_op_ready;
    assign o_in_data   = o_in_valid ? skid0_p1 : 8'd0;
    assign accept      = o_in_valid && i_in_ready;
    assign fill        = {1'b0, occ_p0} + {2'b0, rd_vld_p1} - {2'b0, accept};
    assign o_mem_req   = (state == LOAD) && (addr_q < N_BYTES) && (fill < 3'd2);
    assign o_mem_addr  = addr_q[ADDR_W-1:0];
    assign o_cmd_ready = !fifo_full;
    assign o_busy      = (state != IDLE) || !fifo_empty;
    assign o_load_done = (state == DONE);

    always_comb begin
        state_d    = state;
        pend_d     = ready_pend;
        fifo_pop   = 1'b0;
        o_op_valid = 1'b0;
        o_op_mode  = 4'd0;
        case (state)
            IDLE: begin
                if ((ready_pend || i_op_ready) && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    pend_d   = 1'b0;
                    state_d  = ISSUE;
                end else if (i_op_ready) begin
                    pend_d = 1'b1;
                end
            end
            ISSUE: begin
                if (i_op_ready) begin
                    pend_d = 1'b1;
                end else begin
                    o_op_valid = 1'b1;
                    o_op_mode  = mode_q;
                    state_d    = (mode_q == OP_LOAD) ? LOAD : IDLE;
                end
            end
            LOAD: begin
                if (i_op_ready) pend_d = 1'b1;
                if (accept && (byte_cnt == LAST_BYTE)) state_d = DONE;
            end
            DONE: begin
                if (i_op_ready) pend_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            ready_pend <= 1'b0;
            occ_p0     <= 2'd0;
            rd_vld_p1  <= 1'b0;
            addr_q     <= '0;
            byte_cnt   <= '0;
        end else begin
            state      <= state_d;
            ready_pend <= pend_d;
            rd_vld_p1  <= o_mem_req;
            occ_p0     <= occ_p0 + {1'b0, rd_vld_p1} - {1'b0, accept};
            if (state == DONE) begin
                addr_q   <= '0;
                byte_cnt <= '0;
            end else begin
                if (o_mem_req) addr_q   <= addr_q + 1'b1;
                if (accept)    byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (fifo_pop) mode_q <= fifo_head;
    end

    // Memory read data lands here one cycle after the request
    always_ff @(posedge i_clk) begin
        if (accept) begin
            if (occ_p0 == 2'd2) begin
                skid0_p1 <= skid1_p1;
                if (rd_vld_p1) skid1_p1 <= i_mem_data;
            end else if (rd_vld_p1) begin
                skid0_p1 <= i_mem_data;
            end
        end else if (rd_vld_p1) begin
            if (occ_p0 == 2'd0) skid0_p1 <= i_mem_data;
            else                skid1_p1 <= i_mem_data;
        end
    end

endmodule

// File: tb/tb_op_sequencer.sv
// Directed-plus-random bench for op_sequencer with a queue-level op model
// and an address-pattern byte memory.
module tb_op_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_cmd_valid;
    logic [3:0]  i_cmd_mode;
    logic        o_cmd_ready;
    logic        o_mem_req;
    logic [10:0] o_mem_addr;
    logic [7:0]  i_mem_data;
    logic        i_op_ready;
    logic        o_op_valid;
    logic [3:0]  o_op_mode;
    logic        i_in_ready;
    logic        o_in_valid;
    logic [7:0]  o_in_data;
    logic        o_busy;
    logic        o_load_done;

    int checks = 0;
    int errors = 0;

    logic [3:0] mq[$];

    int  op_found, op_wait;
    logic [3:0] op_seen;
    int  ld_acc, ld_bad, ld_stall_bad, ld_done, ld_first, ld_last, ld_first_addr;

    op_sequencer dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_cmd_valid (i_cmd_valid),
        .i_cmd_mode  (i_cmd_mode),
        .o_cmd_ready (o_cmd_ready),
        .o_mem_req   (o_mem_req),
        .o_mem_addr  (o_mem_addr),
        .i_mem_data  (i_mem_data),
        .i_op_ready  (i_op_ready),
        .o_op_valid  (o_op_valid),
        .o_op_mode   (o_op_mode),
        .i_in_ready  (i_in_ready),
        .o_in_valid  (o_in_valid),
        .o_in_data   (o_in_data),
        .o_busy      (o_busy),
        .o_load_done (o_load_done)
    );

    always #5 i_clk = ~i_clk;

    // Byte memory: contents are the low address byte, one-cycle read latency
    always @(posedge i_clk) begin
        if (o_mem_req) i_mem_data <= o_mem_addr[7:0];
    end

    always @(negedge i_clk) begin
        if (!i_rst) begin
            checks++;
            assert (!((o_op_valid || o_in_valid) && i_op_ready)) else begin
                errors++;
                $error("FAIL handshake observed op_valid=%0b in_valid=%0b op_ready=%0b required no beat on ready",
                       o_op_valid, o_in_valid, i_op_ready);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic [3:0] mode);
        if (mq.size() < 16) mq.push_back(mode);
        i_cmd_valid = 1'b1;
        i_cmd_mode  = mode;
        tick();
        i_cmd_valid = 1'b0;
        i_cmd_mode  = 4'd0;
    endtask

    task automatic pulse();
        i_op_ready = 1'b1;
        tick();
        i_op_ready = 1'b0;
    endtask

    task automatic wait_op(input int limit);
        op_found = 0;
        op_wait  = -1;
        op_seen  = 4'hx;
        for (int c = 0; c < limit && op_found == 0; c++) begin
            #4;
            if (o_op_valid) begin
                op_found = 1;
                op_wait  = c;
                op_seen  = o_op_mode;
            end
            tick();
        end
    endtask

    task automatic expect_op(input string tag, input int limit);
        logic [3:0] exp;
        exp = mq.pop_front();
        wait_op(limit);
        check({tag, "_found"}, op_found, 1);
        check({tag, "_mode"}, op_seen, exp);
    endtask

    task automatic do_load(input bit rnd, input int abort_at);
        int  n;
        bit  prev_stall;
        logic [7:0] prev_data;
        bit  stop;
        n = 0; prev_stall = 0; prev_data = 0; stop = 0;
        ld_bad = 0; ld_stall_bad = 0; ld_done = 0;
        ld_first = -1; ld_last = -1; ld_first_addr = -1;
        for (int cyc = 0; cyc < 20000 && !stop; cyc++) begin
            i_in_ready = rnd ? ($urandom_range(0, 99) >= 40) : 1'b1;
            #4;
            if (prev_stall && (!o_in_valid || o_in_data !== prev_data)) ld_stall_bad++;
            if (o_mem_req && ld_first_addr < 0) ld_first_addr = int'(o_mem_addr);
            if (o_in_valid && i_in_ready) begin
                if (o_in_data !== 8'(n % 256)) ld_bad++;
                if (ld_first < 0) ld_first = cyc;
                ld_last = cyc;
                n++;
            end
            prev_stall = o_in_valid && !i_in_ready;
            prev_data  = o_in_data;
            if (o_load_done) begin
                ld_done = 1;
                stop    = 1;
            end
            if (abort_at >= 0 && n == abort_at) stop = 1;
            if (!stop) begin
                @(posedge i_clk);
                #1;
            end
        end
        ld_acc = n;
    endtask

    initial begin
        logic [3:0] m;
        int bad;
        i_rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_mode = 4'd0;
        i_mem_data = 8'd0; i_op_ready = 1'b0; i_in_ready = 1'b0;
        repeat (3) tick();
        i_rst = 1'b0;
        #3;
        check("rst_cmd_ready", o_cmd_ready, 1);
        check("rst_op_valid", o_op_valid, 0);
        check("rst_op_mode", o_op_mode, 0);
        check("rst_in_valid", o_in_valid, 0);
        check("rst_in_data", o_in_data, 0);
        check("rst_mem_req", o_mem_req, 0);
        check("rst_mem_addr", o_mem_addr, 0);
        check("rst_busy", o_busy, 0);
        check("rst_load_done", o_load_done, 0);
        tick();

        // Load then non-load op, core always ready
        push(4'd0);
        push(4'd3);
        check("busy_queued", o_busy, 1);
        pulse();
        expect_op("t1_load", 4);
        check("t1_latency", op_wait, 0);
        do_load(1'b0, -1);
        check("t1_done", ld_done, 1);
        check("t1_count", ld_acc, 2048);
        check("t1_data", ld_bad, 0);
        check("t1_back_to_back", ld_last - ld_first, 2047);
        check("t1_first_addr", ld_first_addr, 0);
        tick();
        pulse();
        expect_op("t1_mode3", 4);
        check("t1_mode3_latency", op_wait, 0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            #4;
            if (o_in_valid || o_mem_req) bad++;
            tick();
        end
        check("t1_mode3_no_data", bad, 0);
        check("t1_idle_busy", o_busy, 0);

        // Load with random backpressure
        push(4'd0);
        pulse();
        expect_op("t2_load", 4);
        do_load(1'b1, -1);
        check("t2_done", ld_done, 1);
        check("t2_count", ld_acc, 2048);
        check("t2_data", ld_bad, 0);
        check("t2_stall_stable", ld_stall_bad, 0);
        tick();
        check("t2_idle_busy", o_busy, 0);

        // Ready pulse arrives before the op is queued
        pulse();
        repeat (2) tick();
        push(4'd5);
        expect_op("t3_pending", 10);

        // Fill the queue, overflow push, drain in order
        for (int i = 0; i < 16; i++) begin
            m = 4'($urandom_range(1, 15));
            check("t4_ready_before_push", o_cmd_ready, 1);
            push(m);
        end
        check("t4_full_ready", o_cmd_ready, 0);
        push(4'd9);
        check("t4_still_full", o_cmd_ready, 0);
        for (int i = 0; i < 16; i++) begin
            pulse();
            expect_op("t4_drain", 4);
        end
        pulse();
        wait_op(5);
        check("t4_overflow_dropped", op_found, 0);
        check("t4_empty_busy", o_busy, 0);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        tick();

        // Reset in the middle of a load
        push(4'd0);
        pulse();
        expect_op("t5_load", 4);
        do_load(1'b0, 1000);
        check("t5_reached_1000", ld_acc, 1000);
        push(4'd7);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        mq.delete();
        #3;
        check("t5_in_valid", o_in_valid, 0);
        check("t5_mem_req", o_mem_req, 0);
        check("t5_cmd_ready", o_cmd_ready, 1);
        check("t5_busy", o_busy, 0);
        check("t5_load_done", o_load_done, 0);
        tick();
        push(4'd0);
        pulse();
        expect_op("t5_reload", 4);
        do_load(1'b0, -1);
        check("t5_first_addr", ld_first_addr, 0);
        check("t5_count", ld_acc, 2048);
        check("t5_data", ld_bad, 0);
        check("t5_done", ld_done, 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
